// File: rtl/gcd_sched.sv
// gcd_sched: round-robin scheduler sharing one multi-cycle GCD engine among NREQ requesters.
// Optional engine watchdog enabled by defining GCD_SCHED_TIMEOUT_EN.
module gcd_sched #(
  parameter int NREQ           = 4,
  parameter int W              = 32,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              eng_start,
  output logic [W-1:0]      eng_a,
  output logic [W-1:0]      eng_b,
  output logic              eng_abort,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_gcd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_gcd,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] id_reg, id_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [W-1:0]   gcd_reg, gcd_next;
  logic           timeout_hit;

  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  idx;
  logic            grant_any;
  logic [W-1:0]    sel_a, sel_b;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*W +: W];
    assign b_arr[gi] = req_b[gi*W +: W];
  end

  // Rotating-priority search: first valid requester at or after ptr, with wrap.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_reg) + k) % NREQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any   = 1'b1;
        grant_id    = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  assign sel_a = a_arr[grant_id];
  assign sel_b = b_arr[grant_id];

  assign req_ready = (state_reg == IDLE && reset_n) ? grant : '0;
  assign eng_start = (state_reg == ISSUE);
  assign eng_a     = a_reg;
  assign eng_b     = b_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = id_reg;
  assign rsp_gcd   = gcd_reg;

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] busy_reg;
  logic          err_reg, err_next;

  assign timeout_hit = (state_reg == WAIT) && !eng_done &&
                       (busy_reg == CW'(TIMEOUT_CYCLES - 1));
  assign eng_abort   = timeout_hit;
  assign rsp_err     = err_reg;

  // Counts WAIT cycles; cleared while issuing so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      err_reg <= err_next;
      if (state_reg == ISSUE)
        busy_reg <= '0;
      else if (state_reg == WAIT)
        busy_reg <= busy_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign eng_abort   = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    gcd_next   = gcd_reg;
`ifdef GCD_SCHED_TIMEOUT_EN
    err_next   = err_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (grant_any) begin
          id_next = grant_id;
          a_next  = sel_a;
          b_next  = sel_b;
`ifdef GCD_SCHED_TIMEOUT_EN
          err_next = 1'b0;
`endif
          // A zero operand makes the answer a|b; no engine round trip needed.
          if (sel_a == '0 || sel_b == '0) begin
            gcd_next   = sel_a | sel_b;
            state_next = RESP;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (eng_done) begin
          gcd_next   = eng_gcd;
          state_next = RESP;
        end else if (timeout_hit) begin
          gcd_next   = '0;
`ifdef GCD_SCHED_TIMEOUT_EN
          err_next   = 1'b1;
`endif
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_next   = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      gcd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      gcd_reg   <= gcd_next;
    end
  end

endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: directed self-checking bench for gcd_sched with a behavioural GCD engine.
// With GCD_SCHED_TIMEOUT_EN defined the DUT is built with a 16-cycle watchdog.
module tb_gcd_sched;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;
`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              eng_start, eng_abort, eng_done;
  logic [W-1:0]      eng_a, eng_b, eng_gcd;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_gcd;

  gcd_sched #(.NREQ(NREQ), .W(W), .IDW(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_abort(eng_abort),
    .eng_done(eng_done), .eng_gcd(eng_gcd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_gcd(rsp_gcd), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state, sampled on the falling edge.
  int         cyc = 0, start_cnt = 0, abort_cnt = 0, ready0_cnt = 0;
  int         start_cyc = 0, abort_cyc = 0;
  logic [W-1:0] last_a = '0, last_b = '0;
  bit         start_seen = 1'b0;

  // Engine model state.
  int         eng_lat = 3;
  bit         eng_mute = 1'b0;
  bit         eng_busy = 1'b0;
  int         eng_cnt = 0;
  logic [W-1:0] eng_res = '0;

  function automatic logic [W-1:0] euclid(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  initial forever begin
    @(negedge clk);
    cyc++;
    start_seen = eng_start;
    if (eng_start) begin
      start_cnt++;
      start_cyc = cyc;
      last_a = eng_a;
      last_b = eng_b;
    end
    if (eng_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (req_ready[0]) ready0_cnt++;
  end

  // Engine replies eng_lat cycles after the cycle following the start pulse.
  initial forever begin
    @(posedge clk);
    #1;
    eng_done = 1'b0;
    if (eng_busy) begin
      eng_cnt--;
      if (eng_cnt <= 0) begin
        eng_done = 1'b1;
        eng_gcd  = eng_res;
        eng_busy = 1'b0;
      end
    end
    if (start_seen && !eng_mute) begin
      eng_busy = 1'b1;
      eng_cnt  = eng_lat;
      eng_res  = euclid(last_a, last_b);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b1;
    req_valid = '1;
    #2 reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0 || eng_start !== 1'b0 || eng_abort !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: rsp_valid=%b eng_start=%b eng_abort=%b want 0", rsp_valid, eng_start, eng_abort);
    end
    checks++;
    if (eng_a !== '0 || eng_b !== '0 || rsp_gcd !== '0 || rsp_id !== '0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_data: eng_a=%0d eng_b=%0d rsp_gcd=%0d rsp_id=%0d rsp_err=%b want 0", eng_a, eng_b, rsp_gcd, rsp_id, rsp_err);
    end
    req_valid = '0;
    reset_n   = 1'b1;
    tick();
  endtask

  task automatic test_round_robin;
    int exp_id [5]  = '{0, 1, 2, 3, 0};
    int exp_gcd [5] = '{4, 3, 7, 7, 4};
    bit got;
    eng_lat = 3;
    set_req(0, 12, 8);
    set_req(1, 9, 6);
    set_req(2, 35, 14);
    set_req(3, 21, 14);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_grant: got %b want 0001", req_ready); end
    for (int k = 0; k < 5; k++) begin
      wait_rsp(got);
      checks++;
      if (!got) begin
        errors++; $display("FAIL rr_rsp_timeout[%0d]: got no response want response", k);
      end else begin
        checks++;
        if (rsp_id !== IDW'(exp_id[k])) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, rsp_id, exp_id[k]); end
        checks++;
        if (rsp_gcd !== W'(exp_gcd[k])) begin errors++; $display("FAIL rr_gcd[%0d]: got %0d want %0d", k, rsp_gcd, exp_gcd[k]); end
      end
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single;
    int s0 = start_cnt;
    int r0 = ready0_cnt;
    bit got;
    eng_lat = 5;
    set_req(0, 48, 18);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    wait_rsp(got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL single_rsp_timeout: got no response want response");
    end else begin
      checks++;
      if (rsp_id !== 2'd0 || rsp_gcd !== 32'd6 || rsp_err !== 1'b0) begin
        errors++; $display("FAIL single_rsp: got id=%0d gcd=%0d err=%b want id=0 gcd=6 err=0", rsp_id, rsp_gcd, rsp_err);
      end
    end
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
    checks++;
    if (last_a !== 32'd48 || last_b !== 32'd18) begin errors++; $display("FAIL single_operands: got %0d/%0d want 48/18", last_a, last_b); end
    checks++;
    if (ready0_cnt - r0 !== 1) begin errors++; $display("FAIL single_ready_cycles: got %0d want 1", ready0_cnt - r0); end
    tick();
  endtask

  task automatic test_zero_bypass;
    int s0 = start_cnt;
    int exp_b [2] = '{25, 0};
    for (int k = 0; k < 2; k++) begin
      set_req(2, 0, W'(exp_b[k]));
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL zero_grant[%0d]: got %b want 0100", k, req_ready); end
      tick();
      req_valid[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_gcd !== W'(exp_b[k])) begin
        errors++; $display("FAIL zero_rsp[%0d]: got valid=%b id=%0d gcd=%0d want valid=1 id=2 gcd=%0d", k, rsp_valid, rsp_id, rsp_gcd, exp_b[k]);
      end
      tick();
    end
    checks++;
    if (start_cnt !== s0) begin errors++; $display("FAIL zero_no_start: got %0d starts want 0", start_cnt - s0); end
  endtask

  task automatic test_backpressure;
    int s0 = start_cnt;
    bit got;
    eng_lat   = 2;
    rsp_ready = 1'b0;
    set_req(0, 48, 18);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 9, 6);
    wait_rsp(got);
    checks++;
    if (!got) begin errors++; $display("FAIL bp_rsp_timeout: got no response want response"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_gcd !== 32'd6 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b gcd=%0d id=%0d ready=%b want 1/6/0/0000", i, rsp_valid, rsp_gcd, rsp_id, req_ready);
      end
    end
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL bp_starts: got %0d want 1", start_cnt - s0); end
    rsp_ready = 1'b1;
    tick();
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(got);
    checks++;
    if (!got || rsp_id !== 2'd1 || rsp_gcd !== 32'd3) begin
      errors++; $display("FAIL bp_next_job: got valid=%b id=%0d gcd=%0d want 1/1/3", got, rsp_id, rsp_gcd);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bit got;
    bit bad = 1'b0;
    eng_lat = 8;
    set_req(2, 10, 4);
    tick();
    req_valid[2] = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    set_req(0, 14, 21);
    set_req(2, 10, 4);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || eng_a !== '0 || eng_b !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got valid=%b ready=%b eng_a=%0d eng_b=%0d want 0", rsp_valid, req_ready, eng_a, eng_b);
    end
    tick();
    req_valid = '0;
    reset_n   = 1'b1;
    eng_lat   = 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || eng_start) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL mid_stray_done: got activity after reset want none"); end
    set_req(0, 14, 21);
    set_req(2, 10, 4);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(got);
    checks++;
    if (!got || rsp_id !== 2'd0 || rsp_gcd !== 32'd7) begin
      errors++; $display("FAIL mid_next_job: got valid=%b id=%0d gcd=%0d want 1/0/7", got, rsp_id, rsp_gcd);
    end
    tick();
  endtask

`ifdef GCD_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int a0 = abort_cnt;
    bit got;
    eng_mute = 1'b1;
    set_req(1, 27, 9);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(got);
    checks++;
    if (!got || rsp_err !== 1'b1 || rsp_gcd !== '0 || rsp_id !== 2'd1) begin
      errors++; $display("FAIL to_rsp: got valid=%b err=%b gcd=%0d id=%0d want 1/1/0/1", got, rsp_err, rsp_gcd, rsp_id);
    end
    checks++;
    if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL to_abort_count: got %0d want 1", abort_cnt - a0); end
    checks++;
    if (abort_cyc - start_cyc !== 16) begin errors++; $display("FAIL to_abort_delay: got %0d want 16", abort_cyc - start_cyc); end
    tick();
    eng_mute = 1'b0;
    set_req(2, 8, 12);
    tick();
    req_valid[2] = 1'b0;
    wait_rsp(got);
    checks++;
    if (!got || rsp_err !== 1'b0 || rsp_gcd !== 32'd4 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL to_next_job: got valid=%b err=%b gcd=%0d id=%0d want 1/0/4/2", got, rsp_err, rsp_gcd, rsp_id);
    end
    tick();
  endtask
`endif

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    eng_done  = 1'b0;
    eng_gcd   = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_zero_bypass();
    test_backpressure();
    test_reset_mid();
`ifdef GCD_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/gcd_sched.md
Name: gcd_sched

Overview:
- Round-robin scheduler that shares one multi-cycle GCD engine among NREQ requesters.
- Each requester uses a valid/ready handshake. The block accepts one job at a time, latches its operands, and sequences the engine through start/done.
- It returns the result on a single response channel, tagged with the requester id.
- Zero operands are resolved locally and never reach the engine. The block sits between request sources and the GCD datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 32, operand and result width
- IDW, 2, id width (= clog2(NREQ))
- TIMEOUT_CYCLES, 1024, watchdog limit on engine busy cycles (used only with GCD_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester job valid
- req_a  in  NREQ*W  flattened operand A; slice i = [i*W +: W]
- req_b  in  NREQ*W  flattened operand B
- req_ready  out  NREQ  one-hot grant/accept
- eng_start  out  1  one-cycle start pulse to engine
- eng_a  out  W  engine operand A; held stable from start until done
- eng_b  out  W  engine operand B; held stable from start until done
- eng_abort  out  1  one-cycle abort pulse (timeout only)
- eng_done  in  1  engine completion pulse
- eng_gcd  in  W  engine result, valid with eng_done
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  requester id of the response
- rsp_gcd  out  W  result
- rsp_err  out  1  response is a timeout error

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; round-robin pointer = 0.
  - All outputs are 0, including req_ready, eng_a/eng_b, rsp_*.
  - Any in-flight job is dropped; no response is produced.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational. Exactly one bit is high: the first i with req_valid[i]=1, searching from ptr upward with wrap.
  - With no valid requests, req_ready=0.
  - On accept (valid & ready), latch a, b and id.
  - If a==0 or b==0: result = a|b (gcd(0,0)=0), go to RESP; the engine is not used.
  - Otherwise go to ISSUE.
- ISSUE: eng_start=1 for exactly one cycle; eng_a/eng_b = latched operands; go to WAIT.
- WAIT:
  - On eng_done=1, capture eng_gcd into rsp_gcd and go to RESP.
  - eng_done in any other state is ignored.
  - eng_done in the same cycle as eng_start is not possible; the engine guarantees at least 1 cycle of latency.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_gcd/rsp_err held stable until rsp_ready=1.
  - On the handshake cycle: ptr = (id+1) mod NREQ, go to IDLE.
  - The next accept can occur in the cycle after the handshake.
- Latency:
  - Engine path: accept at cycle T, start at T+1, rsp_valid at D+1, where D is the eng_done cycle.
  - Zero path: rsp_valid at T+1.
- Fairness: a requester holding req_valid is granted within NREQ jobs.
- req_ready is never high outside IDLE. A requester may drop req_valid while not granted, with no effect.
- The pointer only advances on a completed response.

Optional Feature:
- Macro: GCD_SCHED_TIMEOUT_EN.
- Defined:
  - A busy counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before eng_done, the block pulses eng_abort for 1 cycle and goes to RESP with rsp_err=1, rsp_gcd=0.
  - eng_done arriving in the same cycle as the limit wins: normal result, rsp_err=0.
- Not defined:
  - No counter.
  - eng_abort and rsp_err are tied 0.
  - WAIT lasts until eng_done.

Test Plan:
1. Single job: req0 a=48, b=18; engine model replies 6 after 5 cycles -> one start pulse with eng_a=48, eng_b=18; rsp_id=0, rsp_gcd=6, rsp_err=0; req_ready[0] high for exactly 1 cycle.
2. Round-robin: all 4 requesters valid continuously (jobs 12/8, 9/6, 35/14, 21/14) -> grant order 0,1,2,3,0; results 4, 3, 7, 7.
3. Zero bypass: req2 a=0, b=25, then a=0, b=0 -> no eng_start; rsp_gcd=25 then 0; rsp_valid one cycle after each accept.
4. Response backpressure: rsp_ready=0 for 10 cycles after result 6 -> rsp_valid/rsp_gcd stable; req_ready stays 0; no new start.
5. Reset mid-job: reset_n low during WAIT -> outputs 0 immediately; a stray eng_done after reset is ignored; the next job is granted from req0.
6. (GCD_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16) engine never asserts done -> eng_abort pulse after 16 WAIT cycles; rsp_err=1, rsp_gcd=0; the next job proceeds normally.
